// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: channel-scan bus grouping enable/select/data inputs and strobe/data outputs
interface mux_scan_n_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int IW = $clog2(CHANNELS);
  logic                      en;
  logic                      mode;
  logic [IW-1:0]             sel;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          dout;
  logic [CHANNELS-1:0]       an;
  logic [IW-1:0]             idx;
  logic                      tick;
  logic                      blank;
  modport master (output en, mode, sel, din, input dout, an, idx, tick, blank);
  modport slave  (input en, mode, sel, din, output dout, an, idx, tick, blank);
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: prescaled channel scanner with manual select; leading-zero blanking under MUX_SCAN_N_LZ_BLANK_EN
module mux_scan_n #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIV      = 100000
) (
  input logic clk,
  input logic rst,
  mux_scan_n_if.slave io
);
  localparam int IW = $clog2(CHANNELS);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TOP  = CW'(DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
  logic [CW-1:0]    cnt;
  logic             term;
  logic             lz;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] ch [CHANNELS];
  assign term = io.en && cnt == TOP;
  assign pick = io.sel > LAST ? LAST : io.sel;
  // unpack the flat channel bus
  always_comb
    for (int k = 0; k < CHANNELS; k++) ch[k] = io.din[k*WIDTH +: WIDTH];
  // prescaler, channel index and the data/strobe registers that trail idx by one cycle
  always_ff @(posedge clk)
    if (rst) begin
      cnt     <= '0;
      io.idx  <= '0;
      io.dout <= '0;
      io.an   <= '1;
      io.tick <= 1'b0;
    end else begin
      io.tick <= term;
      if (io.en) begin
        cnt     <= term ? '0 : cnt + 1'b1;
        io.idx  <= io.mode ? pick : term ? (io.idx == LAST ? '0 : io.idx + 1'b1) : io.idx;
        io.dout <= ch[io.idx];
      end
      io.an <= io.en && !lz ? ~(CHANNELS'(1) << io.idx) : '1;
    end
`ifdef MUX_SCAN_N_LZ_BLANK_EN
  logic [CHANNELS-1:0] zero_up;
  logic                z;
  // zero_up[k]: channel k and every higher channel are zero
  always_comb begin
    z = 1'b1;
    zero_up = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      z = z && ch[k] == '0;
      zero_up[k] = z;
    end
  end
  assign lz = io.idx != '0 && zero_up[io.idx];
  // blank is registered alongside dout/an and frozen with them when disabled
  always_ff @(posedge clk)
    if (rst) io.blank <= 1'b0;
    else if (io.en) io.blank <= lz;
`else
  assign lz = 1'b0;
  assign io.blank = 1'b0;
`endif
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed scoreboard bench for mux_scan_n (WIDTH=4, CHANNELS=4, DIV=4)
module tb_mux_scan_n;
`ifdef MUX_SCAN_N_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  typedef struct {
    string      tag;
    logic [1:0] idx;
    logic [3:0] dout;
    logic [3:0] an;
    logic       tick;
    logic       blank;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];
  mux_scan_n_if #(.WIDTH(4), .CHANNELS(4)) bus ();
  mux_scan_n #(.WIDTH(4), .CHANNELS(4), .DIV(4)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  function automatic logic [3:0] anx(int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction
  task automatic chk(string tag, string name, logic [3:0] got, logic [3:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s %s observed=%0h expected=%0h", tag, name, got, want);
    end
  endtask
  task automatic step(string tag, logic [1:0] i, logic [3:0] d, logic [3:0] a, logic t, logic b);
    exp_t e;
    e.tag = tag;
    e.idx = i;
    e.dout = d;
    e.an = a;
    e.tick = t;
    e.blank = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "idx", {2'b0, bus.idx}, {2'b0, e.idx});
    chk(e.tag, "dout", bus.dout, e.dout);
    chk(e.tag, "an", bus.an, e.an);
    chk(e.tag, "tick", {3'b0, bus.tick}, {3'b0, e.tick});
    chk(e.tag, "blank", {3'b0, bus.blank}, {3'b0, e.blank});
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.din = 16'h0;
    step("reset0", 0, 0, 4'b1111, 0, 0);
    step("reset1", 0, 0, 4'b1111, 0, 0);
    rst = 1'b0;
    bus.din = 16'h4321;
    bus.en = 1'b1;
    for (int n = 1; n <= 22; n++)
      step("auto", 2'((n / 4) % 4), 4'(((n - 1) / 4) % 4 + 1), anx(((n - 1) / 4) % 4), n % 4 == 0, 0);
    bus.en = 1'b0;
    for (int n = 0; n < 10; n++) step("en_off", 1, 2, 4'b1111, 0, 0);
    bus.en = 1'b1;
    step("resume1", 1, 2, 4'b1101, 0, 0);
    step("resume2", 2, 2, 4'b1101, 1, 0);
    step("resume3", 2, 3, 4'b1011, 0, 0);
    bus.mode = 1'b1;
    bus.sel = 2'd0;
    step("man_sel0a", 0, 3, 4'b1011, 0, 0);
    step("man_sel0b", 0, 1, 4'b1110, 0, 0);
    bus.sel = 2'd2;
    step("man_sel2a", 2, 1, 4'b1110, 1, 0);
    step("man_sel2b", 2, 3, 4'b1011, 0, 0);
    for (int m = 5; m <= 10; m++) step("man_hold", 2, 3, 4'b1011, m == 7, 0);
    bus.mode = 1'b0;
    step("to_auto1", 3, 3, 4'b1011, 1, 0);
    for (int a = 2; a <= 14; a++)
      step("to_auto", 2'((3 + (a - 1) / 4) % 4), 4'((3 + (a - 2) / 4) % 4 + 1),
           anx((3 + (a - 2) / 4) % 4), (a - 1) % 4 == 0, 0);
    rst = 1'b1;
    step("mid_reset", 0, 0, 4'b1111, 0, 0);
    rst = 1'b0;
    for (int n = 1; n <= 4; n++)
      step("post_reset", 2'((n / 4) % 4), 4'(((n - 1) / 4) % 4 + 1), anx(((n - 1) / 4) % 4), n % 4 == 0, 0);
    bus.din = 16'h0050;
    bus.mode = 1'b1;
    bus.sel = 2'd3;
    step("lz_sel3a", 3, 5, 4'b1101, 0, 0);
    step("lz_sel3b", 3, 0, LZ ? 4'b1111 : 4'b0111, 0, LZ);
    bus.sel = 2'd2;
    step("lz_sel2a", 2, 0, LZ ? 4'b1111 : 4'b0111, 0, LZ);
    step("lz_sel2b", 2, 0, LZ ? 4'b1111 : 4'b1011, 1, LZ);
    bus.sel = 2'd1;
    step("lz_sel1a", 1, 0, LZ ? 4'b1111 : 4'b1011, 0, LZ);
    step("lz_sel1b", 1, 5, 4'b1101, 0, 0);
    bus.sel = 2'd0;
    step("lz_sel0a", 0, 5, 4'b1101, 0, 0);
    step("lz_sel0b", 0, 0, 4'b1110, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, legal range 2..16: number of input channels; channel CHANNELS-1 is most significant.
REQ-003 SHALL have parameter DIV, default 100000, minimum 2: prescaler period in clk cycles per scan step.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port en  input  1  scan/output enable.
REQ-007 SHALL have port mode  input  1  0 = auto scan, 1 = manual select.
REQ-008 SHALL have port sel  input  $clog2(CHANNELS)  manual channel index.
REQ-009 SHALL have port din  input  CHANNELS*WIDTH  packed channels, channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port dout  output  WIDTH  registered selected channel data.
REQ-011 SHALL have port an  output  CHANNELS  registered active-low one-hot channel strobe.
REQ-012 SHALL have port idx  output  $clog2(CHANNELS)  registered current channel index.
REQ-013 SHALL have port tick  output  1  one-cycle pulse at each prescaler terminal count.
REQ-014 SHALL have port blank  output  1  registered; 1 when the current channel is suppressed.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 while en=1, wrap to 0, and hold its value while en=0.
REQ-016 tick SHALL be 1 for exactly the cycle after the one in which the prescaler equals DIV-1 with en=1; otherwise 0.
REQ-017 In auto mode, idx SHALL advance by 1 on each cycle where the prescaler equals DIV-1 and en=1, wrapping CHANNELS-1 -> 0.
REQ-018 In manual mode, idx SHALL load sel every cycle with en=1 (1-cycle latency); sel >= CHANNELS SHALL clamp to CHANNELS-1.
REQ-019 dout SHALL equal din channel idx, registered one cycle after idx changes; din changes SHALL propagate to dout in 1 cycle.
REQ-020 an SHALL drive bit idx low and all others high, registered, aligned with dout; when en=0 or blank=1, an SHALL be all ones.
REQ-021 en=0 SHALL freeze idx and dout at their last values.
REQ-022 A manual-to-auto mode switch SHALL continue scanning from the current idx without a prescaler restart; auto-to-manual SHALL take effect on the next cycle.
REQ-023 The prescaler SHALL run in manual mode; tick remains meaningful there.

Reset
REQ-024 rst=1 SHALL set prescaler=0, idx=0, dout=0, an=all ones, tick=0, blank=0 on the next rising clk edge, overriding en, mode and sel.
REQ-025 rst asserted mid-scan SHALL abort the scan; the first step after release SHALL occur DIV cycles after rst deasserts.

Configuration
REQ-026 Macro MUX_SCAN_N_LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-027 With the macro defined, blank SHALL be 1 for channel idx > 0 when that channel and every higher channel equal zero; channel 0 SHALL never be blanked.
REQ-028 With the macro undefined, blank SHALL be tied 0 and no comparison logic SHALL be generated.

Verification (WIDTH=4, CHANNELS=4, DIV=4)
REQ-029 Reset: rst=1 for 2 cycles -> dout=0, an=4'b1111, idx=0, tick=0.
REQ-030 Auto scan: din=16'h4321, en=1, mode=0 -> tick every 4 cycles; idx runs 0,1,2,3,0; dout runs 1,2,3,4,1; an runs 1110,1101,1011,0111.
REQ-031 Manual: mode=1, sel=2 -> idx=2 next cycle, dout=3, an=1011 the cycle after; sel held -> no change on tick.
REQ-032 Enable: en=0 for 10 cycles mid-scan -> an=1111, idx/dout/prescaler frozen; en=1 -> resumes with the same remaining count.
REQ-033 With MUX_SCAN_N_LZ_BLANK_EN: din=16'h0050 -> channels 3 and 2 blank=1 and an=1111; channel 1 shows 5; channel 0 shows 0. Without the macro, blank=0 throughout.
REQ-034 Reset during scan: rst=1 at idx=2 -> idx=0; first tick 4 cycles after release.
